// File: rtl/rgb565_gray_stage.sv
// rgb565_gray_stage
// Pixel stage between the OV5640 capture path (RGB565) and the frame-buffer
// input. Each pixel is converted to luma and repacked as gray RGB565 through a
// 3-stage pipeline. vsync/DE are delayed to match. Pixel, line and frame
// statistics are kept for debug. Everything runs in the camera pixel clock.
//
// Optional feature: define GRAY_THRESH_EN to binarise luma against THRESH
// (Y >= THRESH -> 16'hFFFF, else 16'h0000). Bypass still wins. Latency is
// unchanged.
//
// Ports
//   I_pxl_clk    pixel clock (cmos_pclk), only clock
//   I_rst        synchronous active-high reset
//   I_vs         camera vsync, active high
//   I_de         pixel valid
//   I_data       pixel {R5,G6,B5}
//   I_bypass     pass pixels unchanged; taken at frame start only
//   O_vs/O_de    I_vs/I_de delayed 3 cycles
//   O_data       processed pixel aligned with O_de, 0 when O_de=0
//   O_frame_cnt  completed frames (wraps)
//   O_line_cnt   lines closed in the current frame (saturates)
//   O_frame_ok   last completed frame had V_RES lines of exactly H_RES pixels
//   O_line_err   sticky line-length error for the current frame
module rgb565_gray_stage #(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned THRESH = 128
) (
    input  logic        I_pxl_clk,
    input  logic        I_rst,
    input  logic        I_vs,
    input  logic        I_de,
    input  logic [15:0] I_data,
    input  logic        I_bypass,
    output logic        O_vs,
    output logic        O_de,
    output logic [15:0] O_data,
    output logic [15:0] O_frame_cnt,
    output logic [11:0] O_line_cnt,
    output logic        O_frame_ok,
    output logic        O_line_err
);

    // THRESH is an 8-bit luma level; reject out-of-range values in every build.
    if (THRESH > 255) begin : g_thresh_chk
        $error("THRESH must fit in 8 bits");
    end

    logic vs_prev_q;
    logic de_prev_q;
    logic bypass_q;
    logic frame_start;
    logic line_end;

    assign frame_start = I_vs & ~vs_prev_q;
    assign line_end    = de_prev_q & ~I_de;

    // ---------------- pipeline ----------------
    logic [7:0]  r8, g8, b8;
    logic [14:0] r_prod;
    logic [15:0] g_prod;
    logic [12:0] b_prod;

    always_comb begin
        r8     = {I_data[15:11], I_data[15:13]};
        g8     = {I_data[10:5], I_data[10:9]};
        b8     = {I_data[4:0], I_data[4:2]};
        r_prod = 15'(r8) * 15'd77;
        g_prod = 16'(g8) * 16'd150;
        b_prod = 13'(b8) * 13'd29;
    end

    logic        s1_de_q, s1_vs_q, s1_byp_q;
    logic [15:0] s1_raw_q;
    logic [14:0] s1_r_q;
    logic [15:0] s1_g_q;
    logic [12:0] s1_b_q;

    logic        s2_de_q, s2_vs_q, s2_byp_q;
    logic [15:0] s2_raw_q;
    logic [15:0] s2_sum_q;

    logic [7:0]  y;
    logic [15:0] gray_px;
    logic [15:0] out_px;

    always_comb begin
        y = s2_sum_q[15:8];
`ifdef GRAY_THRESH_EN
        gray_px = (y >= 8'(THRESH)) ? 16'hFFFF : 16'h0000;
`else
        gray_px = {y[7:3], y[7:2], y[7:3]};
`endif
        out_px = s2_byp_q ? s2_raw_q : gray_px;
    end

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            s1_de_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_byp_q <= 1'b0;
            s1_raw_q <= '0;
            s1_r_q   <= '0;
            s1_g_q   <= '0;
            s1_b_q   <= '0;
            s2_de_q  <= 1'b0;
            s2_vs_q  <= 1'b0;
            s2_byp_q <= 1'b0;
            s2_raw_q <= '0;
            s2_sum_q <= '0;
            O_de     <= 1'b0;
            O_vs     <= 1'b0;
            O_data   <= '0;
        end else begin
            s1_de_q  <= I_de;
            s1_vs_q  <= I_vs;
            // The bypass decision travels with the pixel so in-flight pixels of
            // the old frame are not affected by the new frame's setting.
            s1_byp_q <= frame_start ? I_bypass : bypass_q;
            s1_raw_q <= I_data;
            s1_r_q   <= r_prod;
            s1_g_q   <= g_prod;
            s1_b_q   <= b_prod;

            s2_de_q  <= s1_de_q;
            s2_vs_q  <= s1_vs_q;
            s2_byp_q <= s1_byp_q;
            s2_raw_q <= s1_raw_q;
            // Max 255*256 = 65280, fits in 16 bits.
            s2_sum_q <= 16'(s1_r_q) + s1_g_q + 16'(s1_b_q);

            O_de     <= s2_de_q;
            O_vs     <= s2_vs_q;
            O_data   <= s2_de_q ? out_px : 16'h0000;
        end
    end

    // ---------------- statistics ----------------
    logic [11:0] len_q;
    logic [11:0] closed_cnt;
    logic        closed_err;

    // Line counter/error as they stand once any line ending this cycle is
    // closed; used both for normal updates and for latching the frame result.
    always_comb begin
        closed_cnt = O_line_cnt;
        if (line_end && (O_line_cnt != 12'hFFF)) begin
            closed_cnt = O_line_cnt + 12'd1;
        end
        closed_err = O_line_err | (line_end & (len_q != 12'(H_RES)));
    end

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            vs_prev_q   <= 1'b0;
            de_prev_q   <= 1'b0;
            bypass_q    <= 1'b0;
            len_q       <= '0;
            O_line_cnt  <= '0;
            O_line_err  <= 1'b0;
            O_frame_cnt <= '0;
            O_frame_ok  <= 1'b0;
        end else begin
            vs_prev_q <= I_vs;
            de_prev_q <= I_de;
            if (frame_start) begin
                bypass_q    <= I_bypass;
                O_frame_ok  <= (closed_cnt == 12'(V_RES)) && !closed_err;
                O_frame_cnt <= O_frame_cnt + 16'd1;
                O_line_cnt  <= '0;
                O_line_err  <= 1'b0;
                // A pixel on the frame-start cycle opens line 0 of the new frame.
                len_q       <= I_de ? 12'd1 : 12'd0;
            end else begin
                O_line_cnt <= closed_cnt;
                O_line_err <= closed_err;
                if (line_end) begin
                    len_q <= '0;
                end else if (I_de && (len_q != 12'hFFF)) begin
                    len_q <= len_q + 12'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb565_gray_stage.sv
module tb_rgb565_gray_stage;

    localparam int unsigned TB_H = 8;
    localparam int unsigned TB_V = 4;

    logic        clk;
    logic        I_rst;
    logic        I_vs;
    logic        I_de;
    logic [15:0] I_data;
    logic        I_bypass;
    logic        O_vs;
    logic        O_de;
    logic [15:0] O_data;
    logic [15:0] O_frame_cnt;
    logic [11:0] O_line_cnt;
    logic        O_frame_ok;
    logic        O_line_err;

    rgb565_gray_stage #(
        .H_RES (TB_H),
        .V_RES (TB_V),
        .THRESH(128)
    ) dut (
        .I_pxl_clk  (clk),
        .I_rst      (I_rst),
        .I_vs       (I_vs),
        .I_de       (I_de),
        .I_data     (I_data),
        .I_bypass   (I_bypass),
        .O_vs       (O_vs),
        .O_de       (O_de),
        .O_data     (O_data),
        .O_frame_cnt(O_frame_cnt),
        .O_line_cnt (O_line_cnt),
        .O_frame_ok (O_frame_ok),
        .O_line_err (O_line_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        vs;
        logic        de;
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks;
    int          errors;
    logic        vs_prev_m;
    logic        bypass_m;
    logic        byp_drv;
    logic [15:0] frames_m;

    // Reference pixel transform, straight from the luma definition.
    function automatic logic [15:0] model(input logic [15:0] p, input logic byp);
        int unsigned r, g, b, yv;
        logic [7:0]  y8;
        r  = 32'({p[15:11], p[15:13]});
        g  = 32'({p[10:5], p[10:9]});
        b  = 32'({p[4:0], p[4:2]});
        yv = (77 * r + 150 * g + 29 * b) / 256;
        y8 = yv[7:0];
        if (byp) return p;
`ifdef GRAY_THRESH_EN
        return (y8 >= 8'd128) ? 16'hFFFF : 16'h0000;
`else
        return {y8[7:3], y8[7:2], y8[7:3]};
`endif
    endfunction

    // Drive one cycle, push its expected output, and compare the output that is
    // due now (three cycles behind the push).
    task automatic step(input logic vs, input logic de, input logic [15:0] data);
        exp_t e;
        I_vs     = vs;
        I_de     = de;
        I_data   = data;
        I_bypass = byp_drv;
        if (vs && !vs_prev_m) begin
            bypass_m = byp_drv;
            frames_m = frames_m + 16'd1;
        end
        vs_prev_m = vs;
        e.vs   = vs;
        e.de   = de;
        e.data = de ? model(data, bypass_m) : 16'h0000;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() >= 4) begin
            e = sb_q.pop_front();
            checks++;
            if ({O_vs, O_de, O_data} !== {e.vs, e.de, e.data}) begin
                errors++;
                $display("FAIL scoreboard t=%0t got vs=%b de=%b data=%h want vs=%b de=%b data=%h",
                         $time, O_vs, O_de, O_data, e.vs, e.de, e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        I_rst    = 1'b1;
        I_vs     = 1'b0;
        I_de     = 1'b0;
        I_data   = 16'h0000;
        I_bypass = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        I_rst = 1'b0;
        sb_q.delete();
        repeat (3) sb_q.push_back(exp_t'(0));
        vs_prev_m = 1'b0;
        bypass_m  = 1'b0;
        byp_drv   = 1'b0;
        frames_m  = 16'd0;
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 16'($urandom));
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({O_vs, O_de, O_data, O_frame_cnt, O_line_cnt, O_frame_ok, O_line_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got vs=%b de=%b data=%h fc=%h lc=%h ok=%b err=%b want all 0",
                     O_vs, O_de, O_data, O_frame_cnt, O_line_cnt, O_frame_ok, O_line_err);
        end
    endtask

    task automatic test_known_pixels();
        logic [15:0] pix [4];
        logic [15:0] want[4];
        pix[0] = 16'hFFFF; pix[1] = 16'h0000; pix[2] = 16'hF800; pix[3] = 16'h07E0;
`ifdef GRAY_THRESH_EN
        want[0] = 16'hFFFF; want[1] = 16'h0000; want[2] = 16'h0000; want[3] = 16'hFFFF;
`else
        want[0] = 16'hFFFF; want[1] = 16'h0000; want[2] = 16'h4A69; want[3] = 16'h94B2;
`endif
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, pix[k]);
            step(1'b0, 1'b0, 16'h0000);
            step(1'b0, 1'b0, 16'h0000);
            checks++;
            if (O_de !== 1'b1 || O_data !== want[k]) begin
                errors++;
                $display("FAIL known_pixel in=%h got de=%b data=%h want de=1 data=%h",
                         pix[k], O_de, O_data, want[k]);
            end
        end
    endtask

    task automatic check_frame(input string name, input logic ok);
        checks++;
        if (O_frame_cnt !== frames_m || O_frame_ok !== ok || O_line_cnt !== 12'd0
            || O_line_err !== 1'b0) begin
            errors++;
            $display("FAIL %s got fc=%0d ok=%b lc=%0d err=%b want fc=%0d ok=%b lc=0 err=0",
                     name, O_frame_cnt, O_frame_ok, O_line_cnt, O_line_err, frames_m, ok);
        end
    endtask

    task automatic test_full_frame();
        step(1'b1, 1'b0, 16'h0000);
        check_frame("first_vs_partial", 1'b0);
        step(1'b0, 1'b0, 16'h0000);
        for (int l = 0; l < int'(TB_V); l++) send_line(TB_H);
        checks++;
        if (O_line_cnt !== 12'(TB_V) || O_line_err !== 1'b0) begin
            errors++;
            $display("FAIL line_count got lc=%0d err=%b want lc=%0d err=0",
                     O_line_cnt, O_line_err, TB_V);
        end
        step(1'b1, 1'b0, 16'h0000);
        check_frame("full_frame", 1'b1);
        step(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_short_line();
        send_line(TB_H);
        send_line(TB_H - 1);
        checks++;
        if (O_line_err !== 1'b1 || O_line_cnt !== 12'd2) begin
            errors++;
            $display("FAIL short_line got err=%b lc=%0d want err=1 lc=2", O_line_err, O_line_cnt);
        end
        send_line(TB_H);
        send_line(TB_H);
        step(1'b1, 1'b0, 16'h0000);
        check_frame("short_line_frame", 1'b0);
        step(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_bypass();
        byp_drv = 1'b1;
        for (int i = 0; i < int'(TB_H); i++) step(1'b0, 1'b1, 16'hF800);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'hF800);
        byp_drv = 1'b0;
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        checks++;
        if (O_de !== 1'b1 || O_data !== 16'hF800) begin
            errors++;
            $display("FAIL bypass_active got de=%b data=%h want de=1 data=f800", O_de, O_data);
        end
        for (int i = 0; i < int'(TB_H); i++) step(1'b0, 1'b1, 16'($urandom));
        step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        send_line(TB_H);
    endtask

    task automatic test_line_end_at_frame_start();
        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        for (int l = 0; l < int'(TB_V) - 1; l++) send_line(TB_H);
        for (int i = 0; i < int'(TB_H); i++) step(1'b0, 1'b1, 16'($urandom));
        step(1'b1, 1'b0, 16'h0000);
        check_frame("line_end_with_vs", 1'b1);
        step(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_de_on_frame_start();
        step(1'b1, 1'b1, 16'($urandom));
        for (int i = 1; i < int'(TB_H); i++) step(1'b0, 1'b1, 16'($urandom));
        step(1'b0, 1'b0, 16'h0000);
        checks++;
        if (O_line_cnt !== 12'd1 || O_line_err !== 1'b0) begin
            errors++;
            $display("FAIL de_on_vs_line got lc=%0d err=%b want lc=1 err=0", O_line_cnt, O_line_err);
        end
        for (int l = 1; l < int'(TB_V); l++) send_line(TB_H);
        step(1'b1, 1'b0, 16'h0000);
        check_frame("de_on_vs_frame", 1'b1);
        step(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_reset_midline();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'hFFFF);
        I_rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({O_de, O_data, O_frame_cnt, O_line_cnt, O_frame_ok, O_line_err} !== '0) begin
            errors++;
            $display("FAIL reset_midline got de=%b data=%h fc=%0d lc=%0d ok=%b err=%b want all 0",
                     O_de, O_data, O_frame_cnt, O_line_cnt, O_frame_ok, O_line_err);
        end
        do_reset();
        test_full_frame();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        byp_drv   = 1'b0;
        vs_prev_m = 1'b0;
        bypass_m  = 1'b0;
        frames_m  = 16'd0;
        test_reset();
        test_known_pixels();
        test_full_frame();
        test_short_line();
        test_bypass();
        test_line_end_at_frame_start();
        test_de_on_frame_start();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
